// File: rtl/maze_pkg.sv
// maze_pkg: shared types and constants for the episode sequencer
package maze_pkg;
    typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;
    localparam logic [1:0] RES_NONE = 2'b00;
    localparam logic [1:0] RES_OBJ = 2'b01;
    localparam logic [1:0] RES_TRAP = 2'b10;
    localparam logic [1:0] RES_TIMEOUT = 2'b11;
    typedef enum logic [1:0] {
        RC_NONE = RES_NONE,
        RC_OBJ = RES_OBJ,
        RC_TRAP = RES_TRAP,
        RC_TIMEOUT = RES_TIMEOUT
    } res_code_t;
    localparam logic [2:0] PROG_OBJECTIVE = 3'd5;
    localparam logic [2:0] PROG_TRAP = 3'd6;
    localparam int STEP_W = 8;
    localparam int CNT_W = 16;
endpackage

// File: rtl/zone_tracker.sv
// zone_tracker: zone-progress automaton, advancing one zone per enabled step
module zone_tracker
    import maze_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clear,
    input  logic       en,
    input  logic [5:0] zone,
    output logic [2:0] progress,
    output logic [2:0] next_progress
);
    // Forward rules beat the trap rule, so zone6 only traps when no advance applies
    assign next_progress = !en ? progress :
                           zone[0] && progress == 3'd0 ? 3'd1 :
                           zone[1] && progress == 3'd1 ? 3'd2 :
                           zone[2] && progress == 3'd2 ? 3'd3 :
                           zone[3] && progress == 3'd3 ? 3'd4 :
                           zone[4] && progress == 3'd4 ? PROG_OBJECTIVE :
                           progress == PROG_TRAP || zone[5] ? PROG_TRAP : progress;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) progress <= '0;
        else if (clear) progress <= '0;
        else progress <= next_progress;
endmodule

// File: rtl/episode_sequencer.sv
// episode_sequencer: runs agent episodes and reports results; EPISODE_SEQ_STATS_EN adds success/trap counters
module episode_sequencer
    import maze_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ep_start,
    input  logic [STEP_W-1:0] max_steps,
    input  logic              step_valid,
    input  logic [5:0]        zone,
    output logic              ep_busy,
    output logic [2:0]        progress,
    output logic              objective,
    output logic              error,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [1:0]        res_code,
    output logic [STEP_W-1:0] res_steps,
`ifdef EPISODE_SEQ_STATS_EN
    output logic [CNT_W-1:0]  succ_count,
    output logic [CNT_W-1:0]  trap_count,
`endif
    output logic [CNT_W-1:0]  ep_count
);
    state_t state, state_nxt;
    logic [2:0] progress_nxt;
    logic [STEP_W-1:0] steps, steps_nxt, budget;
    logic [1:0] term_code;
    logic accept, start, step_en;

    assign accept = state == REPORT && res_ready;
    assign start = ep_start && (state == IDLE || accept);
    assign step_en = state == RUN && step_valid;
    assign steps_nxt = &steps ? steps : steps + 1'b1;
    assign term_code = progress_nxt == PROG_OBJECTIVE ? RES_OBJ :
                       progress_nxt == PROG_TRAP ? RES_TRAP :
                       budget != '0 && steps_nxt == budget ? RES_TIMEOUT : RES_NONE;

    zone_tracker u_zone_tracker (
        .clk          (clk),
        .rst_n        (rst_n),
        .clear        (start),
        .en           (step_en),
        .zone         (zone),
        .progress     (progress),
        .next_progress(progress_nxt)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (ep_start) state_nxt = RUN;
            RUN:     if (step_valid && term_code != RES_NONE) state_nxt = REPORT;
            REPORT:  if (res_ready) begin
                         if (ep_start) state_nxt = RUN;
                         else state_nxt = IDLE;
                     end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        ep_busy = state != IDLE;
        res_valid = state == REPORT;
        objective = progress == PROG_OBJECTIVE;
        error = progress == PROG_TRAP;
    end

    // Result registers are only loaded on termination and cleared on acceptance
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            budget <= '0;
            steps <= '0;
            res_code <= RES_NONE;
            res_steps <= '0;
        end else if (start) begin
            budget <= max_steps;
            steps <= '0;
            res_code <= RES_NONE;
            res_steps <= '0;
        end else if (step_en) begin
            steps <= steps_nxt;
            if (term_code != RES_NONE) begin
                res_code <= term_code;
                res_steps <= steps_nxt;
            end
        end else if (accept) begin
            res_code <= RES_NONE;
            res_steps <= '0;
        end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) ep_count <= '0;
        else if (accept && !(&ep_count)) ep_count <= ep_count + 1'b1;

`ifdef EPISODE_SEQ_STATS_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            succ_count <= '0;
            trap_count <= '0;
        end else if (accept) begin
            if (res_code == RES_OBJ && !(&succ_count)) succ_count <= succ_count + 1'b1;
            if (res_code == RES_TRAP && !(&trap_count)) trap_count <= trap_count + 1'b1;
        end
`endif
endmodule

// File: tb/tb_episode_sequencer.sv
// tb_episode_sequencer: directed self-checking bench for episode_sequencer
module tb_episode_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ep_start = 1'b0;
    logic [7:0] max_steps = '0;
    logic step_valid = 1'b0;
    logic [5:0] zone = '0;
    logic res_ready = 1'b0;
    logic ep_busy, objective, error, res_valid;
    logic [2:0] progress;
    logic [1:0] res_code;
    logic [7:0] res_steps;
    logic [15:0] ep_count;
`ifdef EPISODE_SEQ_STATS_EN
    logic [15:0] succ_count, trap_count;
`endif
    int total = 0;
    int bad = 0;

    episode_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ep_start  (ep_start),
        .max_steps (max_steps),
        .step_valid(step_valid),
        .zone      (zone),
        .ep_busy   (ep_busy),
        .progress  (progress),
        .objective (objective),
        .error     (error),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_code  (res_code),
        .res_steps (res_steps),
`ifdef EPISODE_SEQ_STATS_EN
        .succ_count(succ_count),
        .trap_count(trap_count),
`endif
        .ep_count  (ep_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_ep(input logic [7:0] budget);
        ep_start = 1'b1;
        max_steps = budget;
        tick();
        ep_start = 1'b0;
    endtask

    task automatic step(input logic [5:0] z);
        step_valid = 1'b1;
        zone = z;
        tick();
        step_valid = 1'b0;
        zone = '0;
    endtask

    task automatic accept_res();
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    initial begin
        logic [5:0] path [5];
        path[0] = 6'h01; path[1] = 6'h02; path[2] = 6'h04; path[3] = 6'h08; path[4] = 6'h10;
        #12;
        chk("rst_busy", ep_busy, 0);
        chk("rst_valid", res_valid, 0);
        chk("rst_prog", progress, 0);
        chk("rst_code", res_code, 0);
        chk("rst_count", ep_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // objective path
        start_ep(8'd10);
        chk("obj_busy", ep_busy, 1);
        chk("obj_prog0", progress, 0);
        for (int i = 0; i < 4; i++) step(path[i]);
        chk("obj_prog4", progress, 4);
        chk("obj_novalid", res_valid, 0);
        step(path[4]);
        chk("obj_valid", res_valid, 1);
        chk("obj_code", res_code, 2'b01);
        chk("obj_steps", res_steps, 5);
        chk("obj_flag", objective, 1);
        accept_res();
        chk("obj_cnt", ep_count, 1);
        chk("obj_idle", ep_busy, 0);
        chk("obj_code_clr", res_code, 0);
        chk("obj_steps_clr", res_steps, 0);
        chk("obj_prog_keep", progress, 5);
        step(6'h20);
        chk("idle_step_ign", progress, 5);
        chk("idle_stays", ep_busy, 0);

        // timeout path, with ep_start ignored in RUN and holds without steps
        start_ep(8'd3);
        step(6'h00);
        step(6'h00);
        ep_start = 1'b1;
        tick();
        tick();
        ep_start = 1'b0;
        chk("to_hold_busy", ep_busy, 1);
        chk("to_hold_valid", res_valid, 0);
        step(6'h00);
        chk("to_valid", res_valid, 1);
        chk("to_code", res_code, 2'b11);
        chk("to_steps", res_steps, 3);
        chk("to_prog", progress, 0);
        accept_res();
        chk("to_cnt", ep_count, 2);

        // trap path with skipped zone and zone1 priority
        start_ep(8'd0);
        step(6'h02);
        chk("skip_hold", progress, 0);
        step(6'h21);
        chk("z1_wins", progress, 1);
        chk("z1_noterm", res_valid, 0);
        step(6'h20);
        chk("trap_code", res_code, 2'b10);
        chk("trap_err", error, 1);
        chk("trap_steps", res_steps, 3);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("stall_valid", res_valid, 1);
            chk("stall_code", res_code, 2'b10);
        end
        res_ready = 1'b1;
        ep_start = 1'b1;
        max_steps = 8'd0;
        tick();
        res_ready = 1'b0;
        ep_start = 1'b0;
        chk("b2b_busy", ep_busy, 1);
        chk("b2b_valid", res_valid, 0);
        chk("b2b_prog", progress, 0);
        chk("b2b_cnt", ep_count, 3);

        // unlimited budget, step count saturates at 255
        for (int i = 0; i < 300; i++) step(6'h00);
        chk("unl_busy", ep_busy, 1);
        chk("unl_valid", res_valid, 0);
        for (int i = 0; i < 5; i++) step(path[i]);
        chk("sat_code", res_code, 2'b01);
        chk("sat_steps", res_steps, 255);
        accept_res();
        chk("sat_cnt", ep_count, 4);
`ifdef EPISODE_SEQ_STATS_EN
        chk("succ_cnt", succ_count, 2);
        chk("trap_cnt", trap_count, 1);
`endif

        // asynchronous reset mid-run
        start_ep(8'd10);
        for (int i = 0; i < 3; i++) step(path[i]);
        chk("pre_rst_prog", progress, 3);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_prog", progress, 0);
        chk("arst_busy", ep_busy, 0);
        chk("arst_cnt", ep_count, 0);
        chk("arst_valid", res_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", ep_busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
